// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction-memory writer. Streams 32-bit words
//                into consecutive imem addresses, reads them back, checks an
//                additive checksum and only then releases the processor reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int READ_LAT   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  imem_wren,
    input  logic [31:0]           imem_q,
    output logic                  proc_reset,
    output logic                  done,
    output logic                  error,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [31:0]           checksum
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_FLUSH  = 3'd2;
    localparam logic [2:0] c_VERIFY = 3'd3;
    localparam logic [2:0] c_RUN    = 3'd4;
    localparam logic [2:0] c_ERROR  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_wren;
    logic                  r_overflow;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic [31:0]           r_checksum;
    logic [31:0]           r_rb_sum;
    logic [ADDR_WIDTH:0]   r_issued;     // read-back addresses driven so far
    logic [ADDR_WIDTH:0]   r_sampled;    // read-back words summed so far
    logic                  r_cmp_pend;   // final sample taken, compare next edge
    logic [READ_LAT-1:0]   r_vpipe;      // tracks which cycles carry valid imem_q

    logic w_hs;
    logic w_issue;
    logic w_sample;

    // Handshake, read-issue and read-sample qualifiers
    always_comb begin
        in_ready = (r_state == c_LOAD);
        w_hs     = in_valid & in_ready;
        w_issue  = (r_state == c_FLUSH) ||
                   ((r_state == c_VERIFY) && (r_issued < r_word_count));
        w_sample = (r_state == c_VERIFY) && r_vpipe[READ_LAT-1];
    end

    // Status outputs decoded from the state; the core runs only in RUN
    always_comb begin
        proc_reset = (r_state != c_RUN);
        done       = (r_state == c_RUN);
        error      = (r_state == c_ERROR);
        imem_addr  = r_addr;
        imem_data  = r_wdata;
        imem_wren  = r_wren;
        overflow   = r_overflow;
        word_count = r_word_count;
        checksum   = r_checksum;
    end

    // Read-latency pipeline: a 1 enters when an address is driven and
    // reaches the top stage on the cycle its data is on imem_q
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    // Main sequencer: load, flush, verify, then run or error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wren       <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
            r_checksum   <= '0;
            r_rb_sum     <= '0;
            r_issued     <= '0;
            r_sampled    <= '0;
            r_cmp_pend   <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                c_LOAD: begin
                    if (w_hs) begin
                        r_wren       <= 1'b1;
                        r_addr       <= r_word_count[ADDR_WIDTH-1:0];
                        r_wdata      <= in_data;
                        r_word_count <= r_word_count + 1'b1;
                        r_checksum   <= r_checksum + in_data;
                        if (in_last) begin
                            r_state <= c_FLUSH;
                        end else if (r_word_count[ADDR_WIDTH-1:0] == c_LAST_ADDR) begin
                            // Memory full: the word just taken is the last one
                            r_state    <= c_FLUSH;
                            r_overflow <= 1'b1;
                        end
                    end
                end
                c_FLUSH: begin
                    r_state    <= c_VERIFY;
                    r_addr     <= '0;
                    r_issued   <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                    r_sampled  <= '0;
                    r_rb_sum   <= '0;
                    r_cmp_pend <= 1'b0;
                end
                c_VERIFY: begin
                    if (r_issued < r_word_count) begin
                        r_addr   <= r_issued[ADDR_WIDTH-1:0];
                        r_issued <= r_issued + 1'b1;
                    end
                    if (w_sample) begin
                        r_rb_sum  <= r_rb_sum + imem_q;
                        r_sampled <= r_sampled + 1'b1;
                        if ((r_sampled + 1'b1) == r_word_count) begin
                            r_cmp_pend <= 1'b1;
                        end
                    end
                    if (r_cmp_pend) begin
                        r_cmp_pend <= 1'b0;
                        r_state    <= (r_rb_sum == r_checksum) ? c_RUN : c_ERROR;
                    end
                end
                default: begin
                    // IDLE, RUN and ERROR all restart a load on start
                    if (start) begin
                        r_state      <= c_LOAD;
                        r_addr       <= '0;
                        r_word_count <= '0;
                        r_checksum   <= '0;
                        r_overflow   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
